// File: rtl/param_processor_core_pkg.sv
// Shared definitions for param_processor_core: default field widths,
// opcode encodings and FSM state encodings.
package param_processor_core_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 32;
  localparam int unsigned DEF_ARG_WIDTH  = 8;
  localparam int unsigned DEF_OP_WIDTH   = 8;
  localparam int unsigned DEF_PC_ADDR    = 0;

  // Opcodes; anything above OP_LAST is undefined and traps.
  // HALT is zero so that a cleared memory stops the core.
  localparam int unsigned OP_HALT   = 0;
  localparam int unsigned OP_ADD    = 1;
  localparam int unsigned OP_SUB    = 2;
  localparam int unsigned OP_MUL    = 3;
  localparam int unsigned OP_DIV    = 4;
  localparam int unsigned OP_LT     = 5;
  localparam int unsigned OP_GT     = 6;
  localparam int unsigned OP_LEQ    = 7;
  localparam int unsigned OP_GEQ    = 8;
  localparam int unsigned OP_EQ     = 9;
  localparam int unsigned OP_NEQ    = 10;
  localparam int unsigned OP_JMP    = 11;
  localparam int unsigned OP_SET    = 12;
  localparam int unsigned OP_SETDS  = 13;
  localparam int unsigned OP_SETDD  = 14;
  localparam int unsigned OP_SETDDI = 15;
  localparam int unsigned OP_LAST   = OP_SETDDI;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_PC,
    S_FETCH_INSN,
    S_DECODE,
    S_RD_A,
    S_RD_B,
    S_RD_IND,
    S_RD_C,
    S_EXEC,
    S_WR_RES,
    S_WR_PC,
    S_HALTED
  } state_e;

endpackage

// File: rtl/param_processor_core_alu.sv
// Combinational execute stage: result and next PC from opcode, operands
// and current PC. Holds the divide-by-zero and jump rules.
module param_processor_core_alu
  import param_processor_core_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned OP_WIDTH   = DEF_OP_WIDTH
) (
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [WORD_WIDTH-1:0] x_i,
  input  logic [WORD_WIDTH-1:0] y_i,
  input  logic [WORD_WIDTH-1:0] currpc_i,
  output logic [WORD_WIDTH-1:0] result_c_o,
  output logic [WORD_WIDTH-1:0] nxtpc_c_o
);

  // Unsigned arithmetic wraps naturally at the word width.
  always_comb begin
    result_c_o = '0;
    nxtpc_c_o  = currpc_i + WORD_WIDTH'(1);
    case (op_i)
      OP_WIDTH'(OP_ADD):    result_c_o = x_i + y_i;
      OP_WIDTH'(OP_SUB):    result_c_o = x_i - y_i;
      OP_WIDTH'(OP_MUL):    result_c_o = x_i * y_i;
      OP_WIDTH'(OP_DIV):    result_c_o = (y_i == '0) ? '1 : x_i / y_i;
      OP_WIDTH'(OP_LT):     result_c_o = WORD_WIDTH'(x_i <  y_i);
      OP_WIDTH'(OP_GT):     result_c_o = WORD_WIDTH'(x_i >  y_i);
      OP_WIDTH'(OP_LEQ):    result_c_o = WORD_WIDTH'(x_i <= y_i);
      OP_WIDTH'(OP_GEQ):    result_c_o = WORD_WIDTH'(x_i >= y_i);
      OP_WIDTH'(OP_EQ):     result_c_o = WORD_WIDTH'(x_i == y_i);
      OP_WIDTH'(OP_NEQ):    result_c_o = WORD_WIDTH'(x_i != y_i);
      OP_WIDTH'(OP_JMP):    if (x_i != '0) nxtpc_c_o = y_i;
      OP_WIDTH'(OP_SET):    result_c_o = x_i;
      OP_WIDTH'(OP_SETDS):  result_c_o = y_i;
      OP_WIDTH'(OP_SETDD):  result_c_o = x_i;
      OP_WIDTH'(OP_SETDDI): result_c_o = x_i;
      default:              result_c_o = '0;
    endcase
  end

endmodule

// File: rtl/param_processor_core.sv
// Multi-cycle memory-to-memory processor core. Fetches PC and an
// op|a|b|c instruction word from external RAM over a req/ready handshake,
// dereferences operands, executes, writes the result and then the PC.
// Optional trace outputs are enabled by defining PROCESSOR_TRACE_EN.
module param_processor_core
  import param_processor_core_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned ARG_WIDTH  = DEF_ARG_WIDTH,
  parameter int unsigned OP_WIDTH   = DEF_OP_WIDTH,
  parameter int unsigned PC_ADDR    = DEF_PC_ADDR
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  run_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ARG_WIDTH-1:0]  mem_addr_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  output logic                  halted_o,
  output logic                  illegal_o,
  output logic                  retired_o
`ifdef PROCESSOR_TRACE_EN
  ,
  output logic [WORD_WIDTH-1:0] trace_pc_o,
  output logic [WORD_WIDTH-1:0] trace_insn_o,
  output logic [WORD_WIDTH-1:0] trace_result_o
`endif
);

  // Field positions inside the instruction word (op at the top).
  localparam int unsigned A_LSB = WORD_WIDTH - OP_WIDTH - ARG_WIDTH;
  localparam int unsigned B_LSB = A_LSB - ARG_WIDTH;
  localparam int unsigned C_LSB = B_LSB - ARG_WIDTH;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ARG_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] currpc_q, currpc_d;
  logic [WORD_WIDTH-1:0] insn_q, insn_d;
  logic [WORD_WIDTH-1:0] x_q, x_d;
  logic [WORD_WIDTH-1:0] y_q, y_d;
  logic [ARG_WIDTH-1:0]  waddr_q, waddr_d;
  logic [WORD_WIDTH-1:0] result_q, result_d;
  logic [WORD_WIDTH-1:0] nxtpc_q, nxtpc_d;
  logic                  halted_q, halted_d;
  logic                  illegal_q, illegal_d;
  logic                  retired_q, retired_d;
  logic                  run_q;

  logic [OP_WIDTH-1:0]   op_w;
  logic [ARG_WIDTH-1:0]  arg_a, arg_b, arg_c;
  logic                  mem_acc;
  logic                  op_uses_b, op_legal;
  logic                  rq_valid, rq_we;
  logic [ARG_WIDTH-1:0]  rq_addr;
  logic [WORD_WIDTH-1:0] rq_wdata;
  logic [WORD_WIDTH-1:0] alu_result, alu_nxtpc;

  assign op_w      = insn_q[WORD_WIDTH-1 -: OP_WIDTH];
  assign arg_a     = insn_q[A_LSB +: ARG_WIDTH];
  assign arg_b     = insn_q[B_LSB +: ARG_WIDTH];
  assign arg_c     = insn_q[C_LSB +: ARG_WIDTH];
  assign mem_acc   = req_q & mem_ready_i;
  assign op_uses_b = (op_w >= OP_WIDTH'(OP_ADD)) && (op_w <= OP_WIDTH'(OP_JMP));
  assign op_legal  = (op_w <= OP_WIDTH'(OP_LAST));

  param_processor_core_alu #(
    .WORD_WIDTH (WORD_WIDTH),
    .OP_WIDTH   (OP_WIDTH)
  ) u_alu (
    .op_i       (op_w),
    .x_i        (x_q),
    .y_i        (y_q),
    .currpc_i   (currpc_q),
    .result_c_o (alu_result),
    .nxtpc_c_o  (alu_nxtpc)
  );

  // State and datapath registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      currpc_q  <= '0;
      insn_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      waddr_q   <= '0;
      result_q  <= '0;
      nxtpc_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      currpc_q  <= currpc_d;
      insn_q    <= insn_d;
      x_q       <= x_d;
      y_q       <= y_d;
      waddr_q   <= waddr_d;
      result_q  <= result_d;
      nxtpc_q   <= nxtpc_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      run_q     <= run_i;
    end
  end

  // Next-state logic; memory states name their request and advance on accept.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    currpc_d  = currpc_q;
    insn_d    = insn_q;
    x_d       = x_q;
    y_d       = y_q;
    waddr_d   = waddr_q;
    result_d  = result_q;
    nxtpc_d   = nxtpc_q;
    illegal_d = illegal_q;
    retired_d = 1'b0;
    rq_valid  = 1'b0;
    rq_we     = 1'b0;
    rq_addr   = '0;
    rq_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH_PC;
      end
      S_FETCH_PC: begin
        rq_valid = 1'b1;
        rq_addr  = ARG_WIDTH'(PC_ADDR);
        if (mem_acc) begin
          currpc_d = mem_rdata_i;
          state_d  = S_FETCH_INSN;
        end
      end
      S_FETCH_INSN: begin
        rq_valid = 1'b1;
        rq_addr  = currpc_q[ARG_WIDTH-1:0];
        if (mem_acc) begin
          insn_d  = mem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        waddr_d = arg_c;
        if (op_w == OP_WIDTH'(OP_HALT)) begin
          state_d = S_HALTED;
        end else if (!op_legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALTED;
        end else if (op_w == OP_WIDTH'(OP_SETDDI)) begin
          x_d     = WORD_WIDTH'(arg_a);
          state_d = S_RD_C;
        end else begin
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        rq_valid = 1'b1;
        rq_addr  = arg_a;
        if (mem_acc) begin
          x_d = mem_rdata_i;
          if (op_uses_b)                          state_d = S_RD_B;
          else if (op_w == OP_WIDTH'(OP_SETDS))   state_d = S_RD_IND;
          else if (op_w == OP_WIDTH'(OP_SETDD))   state_d = S_RD_C;
          else                                    state_d = S_EXEC;
        end
      end
      S_RD_B: begin
        rq_valid = 1'b1;
        rq_addr  = arg_b;
        if (mem_acc) begin
          y_d     = mem_rdata_i;
          state_d = S_EXEC;
        end
      end
      S_RD_IND: begin
        rq_valid = 1'b1;
        rq_addr  = x_q[ARG_WIDTH-1:0];
        if (mem_acc) begin
          y_d     = mem_rdata_i;
          state_d = S_EXEC;
        end
      end
      S_RD_C: begin
        rq_valid = 1'b1;
        rq_addr  = arg_c;
        if (mem_acc) begin
          waddr_d = mem_rdata_i[ARG_WIDTH-1:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_result;
        nxtpc_d  = alu_nxtpc;
        state_d  = (op_w == OP_WIDTH'(OP_JMP)) ? S_WR_PC : S_WR_RES;
      end
      S_WR_RES: begin
        rq_valid = 1'b1;
        rq_we    = 1'b1;
        rq_addr  = waddr_q;
        rq_wdata = result_q;
        if (mem_acc) state_d = S_WR_PC;
      end
      S_WR_PC: begin
        rq_valid = 1'b1;
        rq_we    = 1'b1;
        rq_addr  = ARG_WIDTH'(PC_ADDR);
        rq_wdata = nxtpc_q;
        if (mem_acc) begin
          retired_d = 1'b1;
          state_d   = run_i ? S_FETCH_PC : S_IDLE;
        end
      end
      S_HALTED: begin
        if (run_i && !run_q) state_d = S_FETCH_PC;
      end
      default: state_d = S_IDLE;
    endcase

    // Issue a request once per memory state; hold it until accepted.
    if (rq_valid && !req_q) begin
      req_d   = 1'b1;
      we_d    = rq_we;
      addr_d  = rq_addr;
      wdata_d = rq_wdata;
    end else if (mem_acc) begin
      req_d = 1'b0;
    end

    halted_d = (state_d == S_HALTED);
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign halted_o    = halted_q;
  assign illegal_o   = illegal_q;
  assign retired_o   = retired_q;

`ifdef PROCESSOR_TRACE_EN
  logic [WORD_WIDTH-1:0] trace_pc_q, trace_insn_q, trace_result_q;

  // Snapshot of the instruction being retired, valid alongside retired_o.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      trace_pc_q     <= '0;
      trace_insn_q   <= '0;
      trace_result_q <= '0;
    end else if ((state_q == S_WR_PC) && mem_acc) begin
      trace_pc_q     <= currpc_q;
      trace_insn_q   <= insn_q;
      trace_result_q <= (op_w == OP_WIDTH'(OP_JMP)) ? '0 : result_q;
    end
  end

  assign trace_pc_o     = trace_pc_q;
  assign trace_insn_o   = trace_insn_q;
  assign trace_result_o = trace_result_q;
`endif

endmodule
